// File: rtl/lab_pkg.sv
// Shared types and constants for the four-LAB readout sequencer.
// Holds the state enum, lab index type and the FIFO word bundle.
`timescale 1ns/1ps
package lab_pkg;

  localparam int NLAB       = 4;
  localparam int LAB_WORDS  = 1536;
  localparam int LAB_ADDR_W = 13;
  localparam int WORD_W     = 11;
  localparam int DAT_W      = 32;
  localparam int FIFO_DEPTH = 4;

  typedef logic [1:0]      lab_idx_t;
  typedef logic [NLAB-1:0] lab_mask_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DIGI,
    ST_WAIT,
    ST_READ,
    ST_NEXT
  } state_e;

  typedef struct packed {
    logic [DAT_W-1:0] dat;
    lab_idx_t         lab;
    logic             last;
  } rd_word_t;

  function automatic lab_idx_t lowest_lab(lab_mask_t m);
    lowest_lab = '0;
    for (int i = NLAB - 1; i >= 0; i--) begin
      if (m[i]) lowest_lab = lab_idx_t'(i);
    end
  endfunction

endpackage

// File: rtl/lab_readout_sequencer_if.sv
// Readout word stream: data plus lab/last tags, valid/ready handshake.
// master drives dat/lab/last/valid, slave drives ready.
`timescale 1ns/1ps
interface lab_readout_sequencer_if;
  import lab_pkg::*;

  logic [DAT_W-1:0] out_dat;
  lab_idx_t         out_lab;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_dat,
    output out_lab,
    output out_last,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_dat,
    input  out_lab,
    input  out_last,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/lab_readout_sequencer_readout_fifo.sv
// 4-deep sync FIFO of readout words; its head drives the stream directly.
// Ports: clk_i, rst_n_i, push_i/push_word_i in, count_o out, strm (master).
`timescale 1ns/1ps
module readout_fifo
  import lab_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       push_i,
  input  rd_word_t   push_word_i,
  output logic [2:0] count_o,
  lab_readout_sequencer_if.master strm
);

  typedef logic [1:0] ptr_t;

  rd_word_t   mem_q [FIFO_DEPTH];
  rd_word_t   mem_d [FIFO_DEPTH];
  ptr_t       wr_q, wr_d;
  ptr_t       rd_q, rd_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pop;
  rd_word_t   head;

  assign head = mem_q[rd_q];
  assign pop  = strm.out_valid & strm.out_ready;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) begin
      mem_d[wr_q] = push_word_i;
      wr_d        = wr_q + 2'd1;
    end
    if (pop) rd_d = rd_q + 2'd1;
    case ({push_i, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign strm.out_valid = (cnt_q != 3'd0);
  assign strm.out_dat   = head.dat;
  assign strm.out_lab   = head.lab;
  assign strm.out_last  = head.last;
  assign count_o        = cnt_q;

endmodule

// File: rtl/lab_readout_sequencer.sv
// Trigger -> hold -> digitize -> per-LAB done wait and RAM sweep sequencer.
// Ports: trig/mask in; hold/digitize/addr out; dat/done in; out_if stream; busy/err/trig_drop status.
`timescale 1ns/1ps
module lab_readout_sequencer
  import lab_pkg::*;
#(
  parameter int WORDS        = LAB_WORDS,
  parameter int HOLD_SETTLE  = 8,
  parameter int DONE_TIMEOUT = 65535,
  parameter int RD_LAT       = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  trig_i,
  input  logic [NLAB-1:0]       trig_mask_i,
  output logic [NLAB-1:0]       hold_o,
  output logic [NLAB-1:0]       digitize_o,
  output logic [LAB_ADDR_W-1:0] addr_o,
  input  logic [DAT_W-1:0]      dat_i,
  input  logic                  done_i,
  output logic                  busy_o,
  output logic [NLAB-1:0]       err_o,
  output logic                  trig_drop_o,
  lab_readout_sequencer_if.master out_if
);

  localparam logic [15:0] SETTLE_LAST = 16'(HOLD_SETTLE - 1);
  localparam logic [15:0] TMO_LAST    = 16'(DONE_TIMEOUT - 1);
  localparam logic [15:0] DONE_GUARD  = 16'd2;
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS - 1);

  state_e      state_q, state_d;
  lab_mask_t   mask_q, mask_d;
  lab_mask_t   hold_q, hold_d;
  lab_mask_t   digi_q, digi_d;
  lab_mask_t   err_q, err_d;
  logic        busy_q, busy_d;
  logic        drop_q, drop_d;
  lab_idx_t    lab_q, lab_d;
  logic [15:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic        issued_q, issued_d;

  // read-latency pipeline: valid bit plus {lab,last} tag per stage
  logic [RD_LAT-1:0]      vld_q, vld_d;
  logic [RD_LAT-1:0][2:0] tag_q, tag_d;

  logic       issue;
  logic       push;
  rd_word_t   push_word;
  logic [2:0] fifo_cnt;
  logic [2:0] fifo_free;
  logic [2:0] infl;
  logic       credit;
  lab_mask_t  remain;

  always_comb begin
    infl = '0;
    for (int i = 0; i < RD_LAT; i++) infl = infl + {2'b0, vld_q[i]};
  end

  // a word is issued only when the FIFO can absorb it plus
  // everything already in flight, so a stalled sink never overflows
  assign fifo_free = 3'(FIFO_DEPTH) - fifo_cnt;
  assign credit    = fifo_free > infl;
  assign remain    = mask_q & ~(lab_mask_t'(1) << lab_q);

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    hold_d   = hold_q;
    digi_d   = '0;
    err_d    = err_q;
    busy_d   = busy_q;
    drop_d   = 1'b0;
    lab_d    = lab_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    issued_d = issued_q;
    issue    = 1'b0;

    if (trig_i && (busy_q || trig_mask_i == '0)) drop_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (trig_i && trig_mask_i != '0) begin
          mask_d  = trig_mask_i;
          hold_d  = trig_mask_i;
          err_d   = '0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          digi_d  = mask_q;
          state_d = ST_DIGI;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DIGI: begin
        lab_d    = lowest_lab(mask_q);
        word_d   = '0;
        issued_d = 1'b0;
        cnt_d    = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // first two cycles may still show the previous event's done
        if (cnt_q >= DONE_GUARD && done_i) begin
          state_d = ST_READ;
        end else if (cnt_q == TMO_LAST) begin
          err_d[lab_q]  = 1'b1;
          hold_d[lab_q] = 1'b0;
          state_d       = ST_NEXT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_READ: begin
        if (!issued_q) begin
          if (credit) begin
            issue = 1'b1;
            if (word_q == WORD_LAST) issued_d = 1'b1;
            else word_d = word_q + 1'b1;
          end
        end else if (vld_q == '0) begin
          hold_d[lab_q] = 1'b0;
          state_d       = ST_NEXT;
        end
      end
      ST_NEXT: begin
        mask_d = remain;
        if (remain != '0) begin
          lab_d    = lowest_lab(remain);
          word_d   = '0;
          issued_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_WAIT;
        end else begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vld_d    = vld_q;
    tag_d    = tag_q;
    vld_d[0] = issue;
    tag_d[0] = {lab_q, word_q == WORD_LAST};
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  assign push           = vld_q[RD_LAT-1];
  assign push_word.dat  = dat_i;
  assign push_word.lab  = tag_q[RD_LAT-1][2:1];
  assign push_word.last = tag_q[RD_LAT-1][0];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      hold_q   <= '0;
      digi_q   <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
      lab_q    <= '0;
      cnt_q    <= '0;
      word_q   <= '0;
      issued_q <= 1'b0;
      vld_q    <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      hold_q   <= hold_d;
      digi_q   <= digi_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
      lab_q    <= lab_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      issued_q <= issued_d;
      vld_q    <= vld_d;
      tag_q    <= tag_d;
    end
  end

  readout_fifo u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (push),
    .push_word_i (push_word),
    .count_o     (fifo_cnt),
    .strm        (out_if)
  );

  assign hold_o      = hold_q;
  assign digitize_o  = digi_q;
  assign addr_o      = {lab_q, word_q};
  assign busy_o      = busy_q;
  assign err_o       = err_q;
  assign trig_drop_o = drop_q;

endmodule

// File: tb/tb_lab_readout_sequencer.sv
// Scoreboard bench for lab_readout_sequencer: RAM/done model, random ready,
// expected words queued per trigger and popped by a stream monitor.
`timescale 1ns/1ps
module tb_lab_readout_sequencer;
  import lab_pkg::*;

  localparam int WORDS        = 1536;
  localparam int HOLD_SETTLE  = 8;
  localparam int DONE_TIMEOUT = 100;
  localparam int RD_LAT       = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig = 1'b0;
  logic [3:0]  trig_mask = 4'h0;
  logic [3:0]  hold, digitize, err;
  logic [12:0] addr;
  logic [31:0] dat = '0;
  logic        done = 1'b0;
  logic        busy, trig_drop;

  lab_readout_sequencer_if sif ();

  lab_readout_sequencer #(
    .WORDS        (WORDS),
    .HOLD_SETTLE  (HOLD_SETTLE),
    .DONE_TIMEOUT (DONE_TIMEOUT),
    .RD_LAT       (RD_LAT)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .trig_i      (trig),
    .trig_mask_i (trig_mask),
    .hold_o      (hold),
    .digitize_o  (digitize),
    .addr_o      (addr),
    .dat_i       (dat),
    .done_i      (done),
    .busy_o      (busy),
    .err_o       (err),
    .trig_drop_o (trig_drop),
    .out_if      (sif)
  );

  always #5 clk = ~clk;

  typedef logic [34:0] exp_t;
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  int         done_dly = 10;
  logic       stuck = 1'b0;
  logic [3:0] dead = 4'h0;
  int         dcnt = 1000000;
  logic       rand_ready = 1'b0;
  logic       ready_lvl = 1'b1;
  logic [12:0] hist [RD_LAT+1];

  function automatic logic [31:0] ram_word(int lab, int w);
    logic [10:0] wv;
    wv = 11'(w);
    return {4'hA, 2'(lab), wv, 4'h5, wv ^ 11'h2AA};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // LAB RAM with RD_LAT latency, and per-LAB done flags
  initial for (int k = 0; k <= RD_LAT; k++) hist[k] = '0;
  always @(negedge clk) begin
    for (int k = RD_LAT; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = addr;
    dat = ram_word(int'(hist[RD_LAT][12:11]), int'(hist[RD_LAT][10:0]));
    if (digitize != 4'h0) dcnt = 0;
    else if (dcnt < 1000000) dcnt++;
    done = stuck || (!dead[addr[12:11]] && dcnt >= done_dly);
  end

  initial begin
    sif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      sif.out_ready = rand_ready ? ($urandom_range(0, 99) < 30) : ready_lvl;
    end
  end

  logic stall_pend = 1'b0;
  exp_t stall_word;
  always @(negedge clk) begin
    exp_t got, e;
    got = {sif.out_dat, sif.out_lab, sif.out_last};
    if (!rst_n) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) chk("stream_hold", {sif.out_valid, got}, {1'b1, stall_word});
      stall_pend = sif.out_valid && !sif.out_ready;
      stall_word = got;
      if (sif.out_valid && sif.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_extra: got %h, required no word", got);
        end else begin
          e = exp_q.pop_front();
          chk("stream_word", got, e);
        end
      end
    end
  end

  task automatic push_event(input logic [3:0] m, input logic [3:0] dd);
    for (int l = 0; l < 4; l++)
      if (m[l] && !dd[l])
        for (int w = 0; w < WORDS; w++)
          exp_q.push_back({ram_word(l, w), 2'(l), w == WORDS - 1});
  endtask

  task automatic trigger(input logic [3:0] m);
    @(posedge clk);
    #1;
    trig = 1'b1;
    trig_mask = m;
    @(posedge clk);
    #1;
    trig = 1'b0;
    trig_mask = 4'($urandom);
  endtask

  task automatic wait_finish(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: busy=%0b pending=%0d, required idle and drained",
               name, busy, exp_q.size());
    end
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0] m;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_hold", hold, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", addr, 0);
    chk("rst_valid", sif.out_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: mask 0101, done 10 cycles after digitize
    done_dly = 10;
    push_event(4'b0101, 4'h0);
    trigger(4'b0101);
    @(negedge clk);
    chk("t1_hold", hold, 4'b0101);
    chk("t1_busy", busy, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (digitize == 4'h0 && n < 40);
    chk("t1_settle_cycles", n, 8);
    chk("t1_digitize", digitize, 4'b0101);
    @(negedge clk);
    chk("t1_digitize_pulse", digitize, 0);
    wait_finish("t1", 8000);
    chk("t1_hold_end", hold, 0);
    chk("t1_err", err, 0);

    // 6: done stuck high, READ waits for third WAIT cycle
    stuck = 1'b1;
    push_event(4'b0100, 4'h0);
    trigger(4'b0100);
    n = 0;
    while (digitize == 4'h0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t6_digitize", digitize, 4'b0100);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("t6_wait_addr", addr, {2'd2, 11'(k <= 4 ? 0 : 1)});
    end
    wait_finish("t6", 5000);
    stuck = 1'b0;

    // 2: random ready (30%), random mask and done delay
    rand_ready = 1'b1;
    done_dly = $urandom_range(3, 20);
    m = 4'($urandom_range(1, 15));
    push_event(m, 4'h0);
    trigger(m);
    wait_finish("t2", 30000);
    rand_ready = 1'b0;

    // 3/4: LAB1 never done, plus dropped triggers
    dead = 4'b0010;
    done_dly = 10;
    push_event(4'b1111, dead);
    trigger(4'b1111);
    repeat (20) @(negedge clk);
    trigger(4'($urandom_range(1, 15)));
    @(negedge clk);
    chk("t4_drop_busy", trig_drop, 1);
    chk("t4_hold_kept", hold, 4'b1111);
    @(negedge clk);
    chk("t4_drop_pulse", trig_drop, 0);
    n = 0;
    while (!(sif.out_valid && sif.out_lab == 2'd2) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("t3_hold_lab2", hold, 4'b1100);
    wait_finish("t3", 8000);
    chk("t3_err", err, 4'b0010);
    chk("t3_hold_end", hold, 0);
    trigger(4'b0000);
    @(negedge clk);
    chk("t4_drop_zero", trig_drop, 1);
    chk("t4_err_kept", err, 4'b0010);
    chk("t4_busy_idle", busy, 0);
    dead = 4'h0;

    // 5: reset mid-READ at word 700 with ready low
    push_event(4'b0011, 4'h0);
    trigger(4'b0011);
    n = 0;
    while (addr[10:0] != 11'd700 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_700", addr[10:0], 700);
    ready_lvl = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t5_hold", hold, 0);
    chk("t5_digitize", digitize, 0);
    chk("t5_addr", addr, 0);
    chk("t5_busy", busy, 0);
    chk("t5_err", err, 0);
    chk("t5_drop", trig_drop, 0);
    chk("t5_valid", sif.out_valid, 0);
    chk("t5_stream", {sif.out_dat, sif.out_lab, sif.out_last}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ready_lvl = 1'b1;
    push_event(4'b1010, 4'h0);
    trigger(4'b1010);
    wait_finish("t5", 8000);
    chk("t5_err_end", err, 0);
    chk("t5_hold_end", hold, 0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
